// File: rtl/moore5_prober.sv
// Sweeps every (state, input) pair of a 5-state Moore DUT.
// Each vector is load -> step -> check; mismatches are collected into err_count / err_map / first_err_idx.
module moore5_prober #(
  parameter int NUM_STATES = 5,
  parameter int NUM_INPUTS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        dut_reset,
  output logic [2:0]  dut_state_in,
  output logic [1:0]  dut_sw,
  output logic        dut_ctrl,
  input  logic [2:0]  dut_state,
  input  logic        dut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [19:0] err_map,
  output logic [4:0]  first_err_idx
);

  localparam int NVEC = NUM_STATES * NUM_INPUTS;

  // Golden next-state table, indexed by vector number k = s*4 + i.
  localparam logic [2:0] GN [20] = '{
    3'd1, 3'd0, 3'd3, 3'd4,
    3'd3, 3'd0, 3'd0, 3'd4,
    3'd2, 3'd2, 3'd3, 3'd1,
    3'd4, 3'd2, 3'd1, 3'd4,
    3'd2, 3'd3, 3'd0, 3'd0};
  // Golden Moore output per state; states 5..7 do not exist and read as 0.
  localparam logic [7:0] GOUT = 8'b0001_0101;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STEP, S_CHECK, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  s_q, s_d;
  logic [1:0]  i_q, i_d;
  logic [4:0]  k_q, k_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [19:0] map_q, map_d;
  logic [4:0]  first_q, first_d;
  logic        dut_reset_q, dut_reset_d;
  logic [2:0]  dut_state_in_q, dut_state_in_d;
  logic [1:0]  dut_sw_q, dut_sw_d;
  logic        dut_ctrl_q, dut_ctrl_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [2:0]  gold_next;
  logic        mismatch;

  always_comb begin
    gold_next = GN[k_q];
    mismatch  = (dut_state != gold_next) || (dut_out != GOUT[gold_next]);
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    i_d     = i_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    map_d   = map_q;
    first_d = first_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          s_d     = 3'd0;
          i_d     = 2'd0;
          k_d     = 5'd0;
          cnt_d   = 5'd0;
          map_d   = 20'd0;
          first_d = 5'd31;
        end
      end
      S_LOAD:  state_d = S_STEP;
      S_STEP:  state_d = S_CHECK;
      S_CHECK: begin
        if (mismatch) begin
          map_d = map_q | (20'd1 << k_q);
          if (cnt_q != 5'd20) cnt_d = cnt_q + 5'd1;
          if (first_q == 5'd31) first_d = k_q;
        end
        k_d = k_q + 5'd1;
        if (i_q == 2'(NUM_INPUTS - 1)) begin
          i_d = 2'd0;
          s_d = s_q + 3'd1;
        end else begin
          i_d = i_q + 2'd1;
        end
        state_d = (k_q == 5'(NVEC - 1)) ? S_DONE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    busy_d         = (state_d == S_LOAD) || (state_d == S_STEP) || (state_d == S_CHECK);
    dut_reset_d    = (state_d == S_LOAD);
    dut_state_in_d = (state_d == S_LOAD) ? s_d : 3'd0;
    dut_ctrl_d     = (state_d == S_STEP);
    dut_sw_d       = busy_d ? i_d : 2'd0;
    done_d         = (state_d == S_DONE);
    pass_d         = (state_d == S_DONE) && (cnt_d == 5'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      s_q            <= 3'd0;
      i_q            <= 2'd0;
      k_q            <= 5'd0;
      cnt_q          <= 5'd0;
      map_q          <= 20'd0;
      first_q        <= 5'd31;
      dut_reset_q    <= 1'b0;
      dut_state_in_q <= 3'd0;
      dut_sw_q       <= 2'd0;
      dut_ctrl_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      s_q            <= s_d;
      i_q            <= i_d;
      k_q            <= k_d;
      cnt_q          <= cnt_d;
      map_q          <= map_d;
      first_q        <= first_d;
      dut_reset_q    <= dut_reset_d;
      dut_state_in_q <= dut_state_in_d;
      dut_sw_q       <= dut_sw_d;
      dut_ctrl_q     <= dut_ctrl_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
    end
  end

  assign dut_reset     = dut_reset_q;
  assign dut_state_in  = dut_state_in_q;
  assign dut_sw        = dut_sw_q;
  assign dut_ctrl      = dut_ctrl_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = cnt_q;
  assign err_map       = map_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_moore5_prober.sv
// Bench for moore5_prober: a configurable faulty Moore DUT, table-driven sweeps,
// corner-case sequences and randomized fault tables checked against a reference model.
module tb_moore5_prober;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        dut_reset, dut_ctrl, dut_out;
  logic [2:0]  dut_state_in, dut_state;
  logic [1:0]  dut_sw;
  logic        busy, done, pass;
  logic [4:0]  err_count, first_err_idx;
  logic [19:0] err_map;

  int tests = 0;
  int fails = 0;

  moore5_prober dut (
    .clk(clk), .reset(reset), .start(start),
    .dut_reset(dut_reset), .dut_state_in(dut_state_in), .dut_sw(dut_sw),
    .dut_ctrl(dut_ctrl), .dut_state(dut_state), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .err_map(err_map), .first_err_idx(first_err_idx));

  always #5 clk = ~clk;

  // Golden machine from the requirement tables.
  int gn[20]  = '{1,0,3,4, 3,0,0,4, 2,2,3,1, 4,2,1,4, 2,3,0,0};
  int gout[5] = '{1,0,1,0,1};

  // Probed DUT: per-vector next state / output, optionally stuck at state 7.
  logic [2:0] dnext[20];
  logic       doutt[20];
  bit         stuck7;
  logic [2:0] m_state = 3'd0;
  logic       m_out = 1'b0;

  always @(posedge clk) begin
    if (stuck7) m_state <= 3'd7;
    else if (dut_reset) m_state <= dut_state_in;
    else if (dut_ctrl) begin
      m_state <= dnext[int'(m_state) * 4 + int'(dut_sw)];
      m_out   <= doutt[int'(m_state) * 4 + int'(dut_sw)];
    end
  end
  assign dut_state = m_state;
  assign dut_out   = m_out;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // mode 0 golden, 1 four listed faults, 2 stuck at 7, 3 random faults
  task automatic set_mode(input int mode);
    stuck7 = (mode == 2);
    for (int k = 0; k < 20; k++) begin
      dnext[k] = 3'(gn[k]);
      doutt[k] = 1'(gout[gn[k]]);
    end
    if (mode == 1) begin
      dnext[5] = 3'd4;  doutt[5] = 1'b0;
      dnext[6] = 3'd4;  doutt[6] = 1'b0;
      dnext[10] = 3'd0;
      doutt[16] = 1'b0;
    end
    if (mode == 3) begin
      for (int k = 0; k < 20; k++) begin
        int r;
        r = int'($urandom_range(0, 3));
        if (r == 0) dnext[k] = 3'($urandom_range(0, 7));
        if (r == 1) doutt[k] = ~doutt[k];
      end
    end
  endtask

  // Reference: a vector fails if the reached state or the reached output differs from golden.
  task automatic model(output logic [19:0] map, output int cnt, output int first);
    map = '0; cnt = 0; first = 31;
    for (int k = 0; k < 20; k++) begin
      bit bad;
      if (stuck7) bad = 1'b1;
      else bad = (int'(dnext[k]) != gn[k]) || (int'(doutt[k]) != gout[gn[k]]);
      if (bad) begin
        map[k] = 1'b1;
        cnt++;
        if (first == 31) first = k;
      end
    end
    if (cnt > 20) cnt = 20;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " dut_reset"}, 32'(dut_reset), 0);
    chk({nm, " dut_state_in"}, 32'(dut_state_in), 0);
    chk({nm, " dut_sw"}, 32'(dut_sw), 0);
    chk({nm, " dut_ctrl"}, 32'(dut_ctrl), 0);
    chk({nm, " busy"}, 32'(busy), 0);
    chk({nm, " done"}, 32'(done), 0);
    chk({nm, " pass"}, 32'(pass), 0);
    chk({nm, " err_count"}, 32'(err_count), 0);
    chk({nm, " err_map"}, 32'(err_map), 0);
    chk({nm, " first_err_idx"}, 32'(first_err_idx), 31);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Called on the first negedge after start was sampled; done must appear 60 edges later.
  task automatic wait_done(input string nm, input bit extra);
    int n;
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      start = extra && (n == 10 || n == 30);
    end
    start = 1'b0;
    chk({nm, " latency"}, 32'(n - 1), 60);
  endtask

  task automatic chk_res(input string nm, input logic [19:0] map, input int cnt,
                         input int first, input bit ps);
    chk({nm, " done"}, 32'(done), 1);
    chk({nm, " busy"}, 32'(busy), 0);
    chk({nm, " err_map"}, 32'(err_map), 32'(map));
    chk({nm, " err_count"}, 32'(err_count), 32'(cnt));
    chk({nm, " first_err_idx"}, 32'(first_err_idx), 32'(first));
    chk({nm, " pass"}, 32'(pass), 32'(ps));
  endtask

  // Per-vector protocol: one LOAD cycle, then one STEP cycle, then CHECK with dut_sw held.
  logic prev_reset = 1'b0, prev_ctrl = 1'b0;
  logic [1:0] prev_sw = 2'd0;
  always @(negedge clk) begin
    if (reset) begin
      prev_reset = 1'b0;
      prev_ctrl  = 1'b0;
    end else begin
      if (dut_reset && dut_ctrl) chk("proto overlap", 1, 0);
      if (prev_reset) chk("proto step_after_load", {30'd0, dut_ctrl, dut_reset}, 32'b10);
      if (prev_ctrl)
        chk("proto check", {27'd0, busy, dut_ctrl, dut_reset, dut_sw}, {27'd0, 1'b1, 2'b00, prev_sw});
      prev_reset = dut_reset;
      prev_ctrl  = dut_ctrl;
      prev_sw    = dut_sw;
    end
  end

  typedef struct {
    string       nm;
    int          mode;
    logic [19:0] map;
    int          cnt;
    int          first;
    bit          ps;
  } vec_t;

  initial begin
    vec_t tbl[3];
    logic [19:0] emap;
    int ecnt, efirst;

    tbl[0] = '{"golden", 0, 20'h00000, 0, 31, 1'b1};
    tbl[1] = '{"faults", 1, 20'h10460, 4, 5, 1'b0};
    tbl[2] = '{"stuck7", 2, 20'hFFFFF, 20, 0, 1'b0};

    reset = 1'b1; start = 1'b0;
    set_mode(0);
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 3; v++) begin
      set_mode(tbl[v].mode);
      pulse_start();
      wait_done(tbl[v].nm, 1'b0);
      chk_res(tbl[v].nm, tbl[v].map, tbl[v].cnt, tbl[v].first, tbl[v].ps);
    end

    // Results held while idle in DONE
    repeat (5) @(negedge clk);
    chk("hold done", 32'(done), 1);
    chk("hold err_map", 32'(err_map), 32'hFFFFF);

    // Start pulses mid-sweep are ignored
    set_mode(1);
    pulse_start();
    wait_done("ignored_start", 1'b1);
    chk_res("ignored_start", 20'h10460, 4, 5, 1'b0);

    // Start in DONE clears results in the same cycle
    set_mode(0);
    pulse_start();
    chk("restart busy", 32'(busy), 1);
    chk("restart done", 32'(done), 0);
    chk("restart err_count", 32'(err_count), 0);
    chk("restart err_map", 32'(err_map), 0);
    chk("restart first_err_idx", 32'(first_err_idx), 31);
    wait_done("restart", 1'b0);
    chk_res("restart", 20'h0, 0, 31, 1'b1);

    // Reset during the CHECK cycle of vector 9
    set_mode(1);
    pulse_start();
    repeat (29) @(negedge clk);
    chk("mid vector9 check", {27'd0, busy, dut_ctrl, dut_reset, dut_sw}, {27'd0, 3'b100, 2'd1});
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("mid_reset");
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    wait_done("after_reset", 1'b0);
    chk_res("after_reset", 20'h10460, 4, 5, 1'b0);

    // Random fault tables against the reference model
    for (int r = 0; r < 6; r++) begin
      set_mode(3);
      model(emap, ecnt, efirst);
      pulse_start();
      wait_done("random", 1'b0);
      chk_res("random", emap, ecnt, efirst, ecnt == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
